render_programmer: RTL and testbench

RENDER_PROGRAMMER -- requirements
Module: render_programmer

---
 rtl/render_pkg.sv | 32 +++
 rtl/prog_fifo.sv | 66 ++++++
 rtl/render_programmer.sv | 140 ++++++++++++++
 tb/tb_render_programmer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared widths, register IDs, FSM encodings and the FIFO entry type for the
// render programmer chain head.
package render_pkg;

  localparam int X_W   = 11;
  localparam int Y_W   = 12;
  localparam int D_W   = 32;
  localparam int REG_W = 3;

  localparam logic [REG_W-1:0] REG_XCOORD = 3'd0;
  localparam logic [REG_W-1:0] REG_YCOORD = 3'd1;
  localparam logic [REG_W-1:0] REG_WIDTH  = 3'd2;
  localparam logic [REG_W-1:0] REG_HEIGHT = 3'd3;
  localparam logic [REG_W-1:0] REG_COLOR  = 3'd4;

  localparam logic [1:0] ST_ACTIVE  = 2'd0;
  localparam logic [1:0] ST_GUARD   = 2'd1;
  localparam logic [1:0] ST_PROGRAM = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  typedef struct packed {
    logic [X_W-1:0]   shape;
    logic [REG_W-1:0] rid;
    logic [D_W-1:0]   data;
  } prog_entry_t;

  // Register IDs travel on the y field, zero-extended.
  function automatic logic [Y_W-1:0] reg_to_y(input logic [REG_W-1:0] r);
    return {{(Y_W-REG_W){1'b0}}, r};
  endfunction

endpackage

// File: rtl/prog_fifo.sv
// First-word-fall-through FIFO of shape-register writes with occupancy count.
// A push at empty only becomes visible at the head on the following cycle.
module prog_fifo
  import render_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  prog_entry_t                din_i,
  input  logic                       pop_i,
  output prog_entry_t                dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  prog_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  // A push at full is only safe when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/render_programmer.sv
// Chain head that interleaves buffered shape-register writes into the pixel
// stream during blanking, with a guard delay and a per-interval beat limit.
module render_programmer
  import render_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter int          GUARD_CYCLES = 2,
  parameter int          MAX_BEATS    = 16,
  parameter logic [31:0] BG_COLOR     = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            blank,
  input  logic [X_W-1:0]  pix_x,
  input  logic [Y_W-1:0]  pix_y,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [X_W-1:0]  wr_shape,
  input  logic [REG_W-1:0] wr_reg,
  input  logic [D_W-1:0]  wr_data,
  output logic            program_out,
  output logic [X_W-1:0]  x_out,
  output logic [Y_W-1:0]  y_out,
  output logic [D_W-1:0]  data_out,
  output logic [6:0]      pending,
  output logic            overflow,
  output logic [1:0]      dbg_state
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES);
  localparam logic [7:0] BEAT_MAX   = 8'(MAX_BEATS);

  logic [1:0]     state_q, state_d;
  logic [3:0]     guard_q, guard_d;
  logic [7:0]     beat_q, beat_d;
  logic           prog_q, prog_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [D_W-1:0] data_q, data_d;
  logic           ovf_q;

  logic           fifo_pop, fifo_full, fifo_empty;
  logic [FAW:0]   fifo_count;
  prog_entry_t    fifo_head, fifo_in;

  // Host write handshake: a write transfers on a rising edge where wr_valid
  // and wr_ready are both high; wr_ready depends only on FIFO occupancy.
  assign wr_ready = !fifo_full;
  assign fifo_in  = '{shape: wr_shape, rid: wr_reg, data: wr_data};

  prog_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_valid && wr_ready),
    .din_i   (fifo_in),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    beat_d   = beat_q;
    fifo_pop = 1'b0;
    prog_d   = 1'b0;
    x_d      = pix_x;
    y_d      = pix_y;
    data_d   = BG_COLOR;
    case (state_q)
      ST_ACTIVE: begin
        if (blank) begin
          guard_d = GUARD_INIT;
          beat_d  = '0;
          state_d = (GUARD_CYCLES == 0) ? ST_PROGRAM : ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (!blank) begin
          state_d = ST_ACTIVE;
        end else begin
          guard_d = guard_q - 1'b1;
          if (guard_q <= 4'd1) state_d = ST_PROGRAM;
        end
      end
      ST_PROGRAM: begin
        // Leaving blanking wins over a pop so no beat lands in active video.
        if (!blank) begin
          state_d = ST_ACTIVE;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          prog_d   = 1'b1;
          x_d      = fifo_head.shape;
          y_d      = reg_to_y(fifo_head.rid);
          data_d   = fifo_head.data;
          beat_d   = beat_q + 1'b1;
          if (beat_q + 8'd1 == BEAT_MAX) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!blank) state_d = ST_ACTIVE;
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACTIVE;
      guard_q <= '0;
      beat_q  <= '0;
      prog_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= BG_COLOR;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      beat_q  <= beat_d;
      prog_q  <= prog_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      ovf_q   <= ovf_q | (wr_valid && !wr_ready);
    end
  end

  assign program_out = prog_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign data_out    = data_q;
  assign pending     = 7'(fifo_count);
  assign overflow    = ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_render_programmer.sv
// Bench for render_programmer: FIFO_DEPTH=8, GUARD_CYCLES=2, MAX_BEATS=4 and a
// non-zero background colour so pixel and programming beats are distinguishable.
module tb_render_programmer;

  localparam int          DEPTH = 8;
  localparam int          GUARD = 2;
  localparam int          MAXB  = 4;
  localparam logic [31:0] BG    = 32'hDEAD_BEEF;
  localparam int          W     = 55;

  logic        clk, rst_n, blank;
  logic [10:0] pix_x, wr_shape, x_out;
  logic [11:0] pix_y, y_out;
  logic        wr_valid, wr_ready, program_out, overflow;
  logic [2:0]  wr_reg;
  logic [31:0] wr_data, data_out;
  logic [6:0]  pending;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int beat_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  render_programmer #(
    .FIFO_DEPTH(DEPTH), .GUARD_CYCLES(GUARD), .MAX_BEATS(MAXB), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .blank(blank), .pix_x(pix_x), .pix_y(pix_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_shape(wr_shape),
    .wr_reg(wr_reg), .wr_data(wr_data), .program_out(program_out),
    .x_out(x_out), .y_out(y_out), .data_out(data_out), .pending(pending),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every programming beat must match the oldest accepted write.
  always @(negedge clk) begin
    if (rst_n && program_out) begin
      beat_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got x=%0d y=%0d data=%h, required no beat", x_out, y_out, data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({x_out, y_out, data_out} !== mon_exp) begin
          errors++;
          $display("FAIL beat_payload: got %h, required %h", {x_out, y_out, data_out}, mon_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_write(input logic [10:0] s, input logic [2:0] r, input logic [31:0] d,
                             input logic exp_ready);
    wr_valid = 1'b1; wr_shape = s; wr_reg = r; wr_data = d;
    checks++;
    if (wr_ready !== exp_ready) begin errors++; $display("FAIL wr_ready: got %b, required %b", wr_ready, exp_ready); end
    if (exp_ready) exp_q.push_back({s, 9'b0, r, d});
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic blank_for(input int n);
    blank = 1'b1;
    repeat (n) tick();
  endtask

  task automatic end_blank();
    blank = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; blank = 1'b0; pix_x = 11'd5; pix_y = 12'd7;
    wr_valid = 1'b0; wr_shape = '0; wr_reg = '0; wr_data = '0;
    tick(); tick();
    checks++; if (program_out !== 1'b0) begin errors++; $display("FAIL rst_prog: got %b, required 0", program_out); end
    checks++; if (x_out !== 11'd0) begin errors++; $display("FAIL rst_x: got %0d, required 0", x_out); end
    checks++; if (y_out !== 12'd0) begin errors++; $display("FAIL rst_y: got %0d, required 0", y_out); end
    checks++; if (data_out !== BG) begin errors++; $display("FAIL rst_data: got %h, required %h", data_out, BG); end
    checks++; if (pending !== 7'd0) begin errors++; $display("FAIL rst_pending: got %0d, required 0", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", wr_ready); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d, required 0", dbg_state); end
    rst_n = 1'b1;
    tick();
    checks++; if ({program_out, x_out, y_out, data_out} !== {1'b0, 11'd5, 12'd7, BG}) begin
      errors++; $display("FAIL first_pixel: got p=%b x=%0d y=%0d d=%h, required p=0 x=5 y=7 d=%h", program_out, x_out, y_out, data_out, BG);
    end
  endtask

  task automatic test_single_beat();
    pix_x = 11'd100; pix_y = 12'd200;
    offer_write(11'd3, 3'd4, 32'hFF00FF00, 1'b1);
    blank = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 4) begin
        checks++; if ({program_out, x_out, y_out, data_out} !== {1'b1, 11'd3, 12'd4, 32'hFF00FF00}) begin
          errors++; $display("FAIL single_beat: got p=%b x=%0d y=%0d d=%h, required p=1 x=3 y=4 d=ff00ff00", program_out, x_out, y_out, data_out);
        end
      end else begin
        checks++; if (program_out !== 1'b0) begin errors++; $display("FAIL single_idle_%0d: got %b, required 0", i, program_out); end
      end
    end
    end_blank();
    checks++; if ({program_out, x_out, data_out} !== {1'b0, 11'd100, BG}) begin
      errors++; $display("FAIL single_resume: got p=%b x=%0d d=%h, required p=0 x=100 d=%h", program_out, x_out, data_out, BG);
    end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL single_state: got %0d, required 0", dbg_state); end
  endtask

  task automatic test_max_beats();
    int b0;
    offer_write(11'd1, 3'd0, $urandom, 1'b1);
    offer_write(11'd1, 3'd0, $urandom, 1'b1);
    offer_write(11'd2, 3'd5, $urandom, 1'b1);
    offer_write(11'd2, 3'd6, $urandom, 1'b1);
    offer_write(11'd7, 3'd7, $urandom, 1'b1);
    offer_write(11'd9, 3'd1, $urandom, 1'b1);
    checks++; if (pending !== 7'd6) begin errors++; $display("FAIL max_fill: got %0d, required 6", pending); end
    b0 = beat_cnt;
    blank_for(20);
    checks++; if (beat_cnt - b0 !== 4) begin errors++; $display("FAIL max_beats: got %0d, required 4", beat_cnt - b0); end
    checks++; if (pending !== 7'd2) begin errors++; $display("FAIL max_pending: got %0d, required 2", pending); end
    checks++; if (dbg_state !== 2'd3) begin errors++; $display("FAIL max_hold: got %0d, required 3", dbg_state); end
    end_blank();
    blank_for(20);
    checks++; if (beat_cnt - b0 !== 6) begin errors++; $display("FAIL max_rest: got %0d, required 6", beat_cnt - b0); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL max_program: got %0d, required 2", dbg_state); end
    end_blank();
  endtask

  task automatic test_overflow();
    int b0;
    for (int i = 0; i < DEPTH; i++) offer_write(11'(40 + i), 3'(i), $urandom, 1'b1);
    checks++; if (pending !== 7'd8) begin errors++; $display("FAIL ovf_full: got %0d, required 8", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b, required 0", overflow); end
    offer_write(11'd99, 3'd2, 32'h0BAD_0BAD, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow); end
    checks++; if (pending !== 7'd8) begin errors++; $display("FAIL ovf_pending: got %0d, required 8", pending); end
    b0 = beat_cnt;
    blank_for(20); end_blank();
    blank_for(20); end_blank();
    checks++; if (beat_cnt - b0 !== 8) begin errors++; $display("FAIL ovf_drain: got %0d, required 8", beat_cnt - b0); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_blank_drop();
    int b0;
    pix_x = 11'd300; pix_y = 12'd400;
    for (int i = 0; i < 5; i++) offer_write(11'(60 + i), 3'(4 - i), $urandom, 1'b1);
    b0 = beat_cnt;
    blank_for(5);
    end_blank();
    checks++; if ({program_out, x_out, y_out} !== {1'b0, 11'd300, 12'd400}) begin
      errors++; $display("FAIL drop_pixel: got p=%b x=%0d y=%0d, required p=0 x=300 y=400", program_out, x_out, y_out);
    end
    checks++; if (pending !== 7'd3) begin errors++; $display("FAIL drop_pending: got %0d, required 3", pending); end
    checks++; if (beat_cnt - b0 !== 2) begin errors++; $display("FAIL drop_beats: got %0d, required 2", beat_cnt - b0); end
    blank_for(20); end_blank();
    checks++; if (beat_cnt - b0 !== 5) begin errors++; $display("FAIL drop_total: got %0d, required 5", beat_cnt - b0); end
  endtask

  task automatic test_back_to_back();
    int occ;
    int b0;
    logic exp_ready;
    logic [31:0] d;
    for (int i = 0; i < DEPTH; i++) offer_write(11'(80 + i), 3'(i), $urandom, 1'b1);
    occ = DEPTH;
    b0 = beat_cnt;
    blank = 1'b1;
    // Pops land on edges 4..7 after blank rises; writes are offered on every edge.
    for (int k = 1; k <= 12; k++) begin
      d = $urandom;
      wr_valid = 1'b1; wr_shape = 11'(100 + k); wr_reg = 3'(k); wr_data = d;
      exp_ready = (occ < DEPTH);
      checks++; if (wr_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready_%0d: got %b, required %b", k, wr_ready, exp_ready); end
      checks++; if (pending !== 7'(occ)) begin errors++; $display("FAIL b2b_pending_%0d: got %0d, required %0d", k, pending, occ); end
      if (exp_ready) exp_q.push_back({11'(100 + k), 9'b0, 3'(k), d});
      tick();
      occ = occ + (exp_ready ? 1 : 0) - ((k >= 4 && k <= 7) ? 1 : 0);
    end
    wr_valid = 1'b0;
    checks++; if (pending !== 7'(occ)) begin errors++; $display("FAIL b2b_final: got %0d, required %0d", pending, occ); end
    end_blank();
    blank_for(20); end_blank();
    blank_for(20); end_blank();
    checks++; if (beat_cnt - b0 !== 12) begin errors++; $display("FAIL b2b_beats: got %0d, required 12", beat_cnt - b0); end
    checks++; if (pending !== 7'd0) begin errors++; $display("FAIL b2b_empty: got %0d, required 0", pending); end
  endtask

  task automatic test_reset_mid_program();
    int b0;
    for (int i = 0; i < 5; i++) offer_write(11'(120 + i), 3'(i), $urandom, 1'b1);
    blank_for(5);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    checks++; if ({program_out, x_out, y_out, data_out} !== {1'b0, 11'd0, 12'd0, BG}) begin
      errors++; $display("FAIL midrst_out: got p=%b x=%0d y=%0d d=%h, required p=0 x=0 y=0 d=%h", program_out, x_out, y_out, data_out, BG);
    end
    checks++; if (pending !== 7'd0) begin errors++; $display("FAIL midrst_pending: got %0d, required 0", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b, required 0", overflow); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d, required 0", dbg_state); end
    rst_n = 1'b1;
    b0 = beat_cnt;
    blank_for(12);
    checks++; if (beat_cnt - b0 !== 0) begin errors++; $display("FAIL midrst_beats: got %0d, required 0", beat_cnt - b0); end
    end_blank();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_max_beats();
    test_overflow();
    test_blank_drop();
    test_back_to_back();
    test_reset_mid_program();
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_writes: got %0d, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
